// File: rtl/num_ascii_tx.sv
// num_ascii_tx: formats a 16-bit word as decimal ASCII with optional '-'
// and a trailing delimiter, one byte at a time into a UART TX byte port.
module num_ascii_tx #(
    parameter logic       SIGNED     = 1'b1,
    parameter logic [7:0] DELIM_CHAR = 8'h20,
    parameter logic [7:0] EOL_CHAR   = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num_in,
    input  logic        eol_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND_SIGN,
        SEND_DIGIT,
        SEND_DELIM,
        WAIT_ACK,
        WAIT_TX,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        B_SIGN,
        B_DIGIT,
        B_DELIM
    } kind_t;

    state_t           state, state_n;
    kind_t            kind, kind_n;
    logic [15:0]      mag, mag_n;
    logic             neg, neg_n;
    logic             eol, eol_n;
    logic [4:0][3:0]  digit, digit_n;
    logic [2:0]       p, p_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       tx_data_n;
    logic             tx_start_n;
    logic             done_n;
    logic [15:0]      pw;
    logic [2:0]       ndig;

    assign in_ready = (state == IDLE);

    always_comb begin
        unique case (p)
            3'd4:    pw = 16'd10000;
            3'd3:    pw = 16'd1000;
            3'd2:    pw = 16'd100;
            3'd1:    pw = 16'd10;
            default: pw = 16'd1;
        endcase
    end

    // Count of printed digits: highest nonzero place + 1, minimum one.
    always_comb begin
        ndig = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (digit[i] != 4'd0) ndig = 3'(i + 1);
        end
    end

    always_comb begin
        state_n    = state;
        kind_n     = kind;
        mag_n      = mag;
        neg_n      = neg;
        eol_n      = eol;
        digit_n    = digit;
        p_n        = p;
        idx_n      = idx;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        done_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    neg_n   = SIGNED & num_in[15];
                    mag_n   = neg_n ? (~num_in + 16'd1) : num_in;
                    eol_n   = eol_in;
                    digit_n = '0;
                    p_n     = 3'd4;
                    state_n = CONV;
                end
            end

            // Restoring decimal conversion: subtract the current power
            // until it no longer fits, then move to the next place.
            CONV: begin
                if (mag >= pw) begin
                    mag_n      = mag - pw;
                    digit_n[p] = digit[p] + 4'd1;
                end else if (p != 3'd0) begin
                    p_n = p - 3'd1;
                end else begin
                    idx_n   = ndig - 3'd1;
                    state_n = neg ? SEND_SIGN : SEND_DIGIT;
                end
            end

            SEND_SIGN: begin
                if (!tx_busy) begin
                    tx_data_n  = 8'h2D;
                    tx_start_n = 1'b1;
                    kind_n     = B_SIGN;
                    state_n    = WAIT_ACK;
                end
            end

            SEND_DIGIT: begin
                if (!tx_busy) begin
                    tx_data_n  = 8'h30 + {4'h0, digit[idx]};
                    tx_start_n = 1'b1;
                    kind_n     = B_DIGIT;
                    state_n    = WAIT_ACK;
                end
            end

            SEND_DELIM: begin
                if (!tx_busy) begin
                    tx_data_n  = eol ? EOL_CHAR : DELIM_CHAR;
                    tx_start_n = 1'b1;
                    kind_n     = B_DELIM;
                    state_n    = WAIT_ACK;
                end
            end

            // tx_busy only rises the cycle after tx_start, so skip one cycle.
            WAIT_ACK: begin
                state_n = WAIT_TX;
            end

            WAIT_TX: begin
                if (!tx_busy) begin
                    unique case (kind)
                        B_SIGN: begin
                            state_n = SEND_DIGIT;
                        end
                        B_DIGIT: begin
                            if (idx != 3'd0) begin
                                idx_n   = idx - 3'd1;
                                state_n = SEND_DIGIT;
                            end else begin
                                state_n = SEND_DELIM;
                            end
                        end
                        default: begin
                            done_n  = 1'b1;
                            state_n = FINISH;
                        end
                    endcase
                end
            end

            FINISH: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            kind     <= B_SIGN;
            mag      <= '0;
            neg      <= 1'b0;
            eol      <= 1'b0;
            digit    <= '0;
            p        <= '0;
            idx      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            kind     <= kind_n;
            mag      <= mag_n;
            neg      <= neg_n;
            eol      <= eol_n;
            digit    <= digit_n;
            p        <= p_n;
            idx      <= idx_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_num_ascii_tx.sv
// tb_num_ascii_tx: drives signed and unsigned instances with directed and
// random numbers against a UART model and a decimal-text reference.
module tb_num_ascii_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_in;
    logic        eol_in;
    logic        hold;
    logic        in_valid_v [2];
    logic        in_ready_v [2];
    logic [7:0]  tx_data_v  [2];
    logic        tx_start_v [2];
    logic        tx_busy_v  [2];
    logic        done_v     [2];
    int          busy_cnt   [2];
    logic        prev_start [2];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    num_ascii_tx #(.SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .num_in(num_in), .eol_in(eol_in),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .tx_data(tx_data_v[0]), .tx_start(tx_start_v[0]),
        .tx_busy(tx_busy_v[0]), .done(done_v[0])
    );

    num_ascii_tx #(.SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .num_in(num_in), .eol_in(eol_in),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .tx_data(tx_data_v[1]), .tx_start(tx_start_v[1]),
        .tx_busy(tx_busy_v[1]), .done(done_v[1])
    );

    assign tx_busy_v[0] = (busy_cnt[0] != 0) || hold;
    assign tx_busy_v[1] = (busy_cnt[1] != 0) || hold;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: busy from the cycle after tx_start for a random time.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tx_start_v[i])
                busy_cnt[i] <= int'($urandom_range(1, 6));
            else if (busy_cnt[i] != 0)
                busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && tx_start_v[i]) begin
                chk("start_vs_busy", 32'(tx_busy_v[i]), 0);
                chk("start_double", 32'(prev_start[i]), 0);
            end
            prev_start[i] <= tx_start_v[i];
        end
    end

    // Reference: decimal text of the value plus delimiter; CONV length is
    // five cycles plus the digit sum of the magnitude.
    task automatic build_exp(input logic [15:0] n, input bit eol,
                             input bit sgn, output int conv_len);
        int v;
        int t;
        int dq [$];
        exp_q.delete();
        v = sgn ? int'($signed(n)) : int'(n);
        if (v < 0) begin
            exp_q.push_back(8'h2D);
            v = -v;
        end
        conv_len = 5;
        t = v;
        repeat (5) begin
            conv_len += t % 10;
            t /= 10;
        end
        t = v;
        do begin
            dq.push_front(t % 10);
            t /= 10;
        end while (t > 0);
        foreach (dq[i]) exp_q.push_back(8'(8'h30 + dq[i]));
        exp_q.push_back(eol ? 8'h0A : 8'h20);
    endtask

    task automatic wait_idle(input int sel);
        int to;
        to = 0;
        @(negedge clk);
        while (!(in_ready_v[sel] && !tx_busy_v[sel]) && to < 200) begin
            @(negedge clk);
            to++;
        end
        chk("idle_wait", 32'(to < 200), 1);
    endtask

    task automatic run_num(input int sel, input logic [15:0] n,
                           input bit eol, input bit keep_valid,
                           input int hold_len);
        int conv_len;
        int cyc;
        int first;
        int dones;
        int starts;
        logic [7:0] got_q [$];
        build_exp(n, eol, sel == 0, conv_len);
        wait_idle(sel);
        num_in = n;
        eol_in = eol;
        in_valid_v[sel] = 1'b1;
        if (hold_len > 0) hold = 1'b1;
        @(negedge clk);
        chk("accept", 32'(in_ready_v[sel]), 0);
        if (!keep_valid) in_valid_v[sel] = 1'b0;
        cyc = 1;
        first = -1;
        dones = 0;
        starts = 0;
        while (dones == 0 && cyc < 3000) begin
            if (keep_valid) begin
                num_in = 16'($urandom);
                eol_in = 1'($urandom);
            end
            if (tx_start_v[sel]) begin
                starts++;
                if (first < 0) first = cyc;
                got_q.push_back(tx_data_v[sel]);
            end
            if (done_v[sel]) dones = 1;
            else chk("ready_low", 32'(in_ready_v[sel]), 0);
            if (hold && cyc == conv_len + hold_len) begin
                chk("bp_quiet", 32'(starts), 0);
                hold = 1'b0;
            end
            if (dones == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid_v[sel] = 1'b0;
        chk("done_seen", 32'(dones), 1);
        if (hold_len == 0)
            chk("first_start", 32'(first), 32'(conv_len + 2));
        else
            chk("bp_release", 32'(first), 32'(conv_len + hold_len + 1));
        chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("byte", 32'(got_q[i]), 32'(exp_q[i]));
        @(negedge clk);
        chk("done_pulse", 32'(done_v[sel]), 0);
        chk("ready_back", 32'(in_ready_v[sel]), 1);
    endtask

    task automatic reset_mid;
        int to;
        int starts;
        wait_idle(0);
        num_in = 16'd12345;
        eol_in = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        to = 0;
        starts = 0;
        while (!(starts == 2 && tx_busy_v[0]) && to < 500) begin
            if (tx_start_v[0]) starts++;
            @(negedge clk);
            to++;
        end
        chk("rst_reach", 32'(to < 500), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready_v[0]), 1);
        chk("rst_start", 32'(tx_start_v[0]), 0);
        chk("rst_done", 32'(done_v[0]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        num_in = '0;
        eol_in = 1'b0;
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(in_ready_v[i]), 1);
            chk("rst_tx_start", 32'(tx_start_v[i]), 0);
            chk("rst_done0", 32'(done_v[i]), 0);
            chk("rst_tx_data", 32'(tx_data_v[i]), 0);
        end
        rst = 1'b0;

        run_num(0, 16'd0, 1'b0, 1'b0, 0);
        run_num(0, 16'hFFE3, 1'b1, 1'b0, 0);
        run_num(0, 16'h8000, 1'b0, 1'b0, 0);
        run_num(0, 16'h7FFF, 1'b0, 1'b0, 0);
        run_num(1, 16'hFFFF, 1'b0, 1'b0, 0);
        run_num(1, 16'h8000, 1'b1, 1'b0, 0);

        run_num(0, 16'd11, 1'b0, 1'b1, 0);
        run_num(0, 16'd21, 1'b1, 1'b1, 0);
        run_num(0, 16'hFFE3, 1'b0, 1'b1, 0);
        run_num(0, 16'd41, 1'b1, 1'b1, 0);

        run_num(0, 16'd305, 1'b0, 1'b0, 50);

        reset_mid();
        run_num(0, 16'd7, 1'b0, 1'b0, 0);

        for (int k = 0; k < 24; k++)
            run_num(int'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom), 1'($urandom), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/num_ascii_tx.md
# num_ascii_tx

Byte-serial formatter that turns one 16-bit result word into its decimal ASCII text, an optional leading '-', and a trailing delimiter, then drives the UART transmitter byte interface. It is the transmit-side counterpart of the command parser: the parser turns "digits + space" into numbers, and this block turns numbers back into "digits + delimiter". The top-level result-readout FSM instantiates it between the result-memory read and the UART TX, and feeds it one element at a time.

## Interface
- SIGNED, 1: 1 means num_in is two's complement; 0 means num_in is unsigned.
- DELIM_CHAR, 8'h20: delimiter byte sent after a number when eol_in=0.
- EOL_CHAR, 8'h0A: delimiter byte sent after a number when eol_in=1.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- num_in  in  16  value to format. Sampled on acceptance.
- eol_in  in  1  delimiter select. Sampled on acceptance.
- in_valid  in  1  a number is offered.
- in_ready  out  1  high only in IDLE. The number is accepted on any edge where in_valid & in_ready.
- tx_data  out  8  byte to the UART TX. Valid and held stable while tx_start=1.
- tx_start  out  1  one-cycle request to the UART TX.
- tx_busy  in  1  UART TX busy. It rises the cycle after tx_start and falls when the stop bit ends.
- done  out  1  one-cycle pulse after the delimiter byte has finished transmitting.

## Operation
States: IDLE, CONV, SEND_SIGN, SEND_DIGIT, SEND_DELIM, WAIT_ACK, WAIT_TX, FINISH.

- **IDLE**
  - in_ready=1.
  - On accept, latch the value:
    - neg = SIGNED & num_in[15].
    - mag = neg ? (~num_in + 1) : num_in, as 16-bit unsigned. For -32768, mag is 32768.
  - Also latch eol_in, clear the five digit registers, set power index p=4, then go to CONV.
- **CONV**: one comparison per cycle against pow[p] ∈ {10000, 1000, 100, 10, 1}.
  - If mag ≥ pow[p]: mag -= pow[p] and digit[p]++.
  - Otherwise, if p>0 then p--. If p==0, conversion is finished.
  - Digit values go up to 6 for the 10000 place (unsigned 65535) and 9 elsewhere.
  - When conversion is finished:
    - ndig = index of the highest nonzero digit + 1, or 1 if the value is zero.
    - Next state is SEND_SIGN if neg, otherwise SEND_DIGIT.
    - The send index starts at ndig-1.
- **SEND_SIGN**: tx_data = 8'h2D ('-').
- **SEND_DIGIT**: tx_data = 8'h30 + digit[idx]. Bytes go out from the most significant digit down to idx 0. Leading zeros are suppressed; zero prints as exactly "0".
- **SEND_DELIM**: tx_data = eol ? EOL_CHAR : DELIM_CHAR.
- **Byte issue rule for every SEND_* state**:
  - If tx_busy=0: assert tx_start for exactly one cycle, then go to WAIT_ACK.
  - If tx_busy=1: stay in the state with tx_start=0.
- **WAIT_ACK**: one cycle, ignoring tx_busy. Then WAIT_TX.
- **WAIT_TX**: hold until tx_busy=0, then advance:
  - sign → first digit.
  - digit with idx>0 → idx-1.
  - digit with idx=0 → delimiter.
  - delimiter → FINISH.
- **FINISH**: done=1 for one cycle, then IDLE.
- **Input handling**:
  - in_valid is ignored outside IDLE; no second number is queued.
  - num_in and eol_in may change freely after acceptance.
- **Reset**: rst forces IDLE on the next edge, even mid-conversion or mid-byte. Any partially formatted number is dropped and never resumed.

## Timing
- Reset values:
  - in_ready=1.
  - tx_start=0, done=0.
  - tx_data=8'h00, state IDLE, all digit registers 0.
- **Acceptance**: accept at edge k → CONV from cycle k+1. in_ready=0 from cycle k+1.
- **CONV length**: (sum of the five decimal digits of mag) + 5 cycles.
  - 0 → 5 cycles.
  - 32767 → 30 cycles.
  - 32768 → 31 cycles.
- **First tx_start**: on the first cycle after CONV in which tx_busy=0. All outputs are registered.
- **Per byte**: 1 cycle (SEND) + 1 cycle (WAIT_ACK) + the tx_busy-high time + 1 cycle. At 115200 baud and 100 MHz, that is about 86.8 µs per byte.
- **Bytes per number**: neg + ndig + 1. Maximum is 7, for "-32768" plus the delimiter.
- **done**: asserted the cycle after tx_busy is observed low following the delimiter. in_ready returns to 1 the cycle after done.
- **Never allowed**:
  - tx_start high for two consecutive cycles.
  - tx_start while tx_busy=1.
  - tx_data changing while tx_start=1.

## Test plan
- num_in=0, eol=0 → UART line carries "0 " (30 20). Exactly one done pulse. CONV lasts 5 cycles.
- num_in=16'hFFE3 (-29), SIGNED=1, eol=1 → "-29\n" (2D 32 39 0A).
- num_in=16'h8000, SIGNED=1 → "-32768 ".
- num_in=16'h7FFF, SIGNED=1 → "32767 ".
- num_in=16'hFFFF, SIGNED=0 → "65535 ".
- Back-to-back matrix [[11,21],[-29,41]], with eol on each row end → "11 21\n-29 41\n".
  - in_valid is held high during sends and the bench checks that no extra number is accepted.
- Backpressure: hold tx_busy=1 for 50 cycles after conversion → no tx_start during that window. When tx_busy is released, tx_start fires once.
- Reset mid-operation: assert rst for 1 cycle while the second digit of 12345 is in WAIT_TX → the next cycle shows IDLE, tx_start=0, done=0 and in_ready=1. A subsequent num_in=7 prints "7 " cleanly.
